// File: rtl/tx_nt1_serializer.sv
// ---------------------------------------------------------------------------
// tx_nt1_serializer
// WIDTH:1 serializer for the TX path, clocked at the bit rate.
// Words arrive over valid/ready into a one-word holding buffer and are
// shifted out one bit per clock, LSB- or MSB-first. When no word is waiting
// at a word boundary the programmable IDLE_WORD is sent instead and the
// underflow is recorded.
//
// Ports
//   clk_b      bit-rate clock, rising edge
//   rst_n      async active-low reset
//   en         serializer enable
//   din        parallel word in
//   din_valid  din holds a word
//   din_ready  holding buffer can take din this cycle
//   dout       serial bit, straight from the shift register
//   frame      first bit of a loaded word is on dout
//   underflow  sticky: an idle word was substituted
//   uf_count   saturating count of idle substitutions
//   clr_uf     synchronous clear of underflow / uf_count
// ---------------------------------------------------------------------------
module tx_nt1_serializer #(
   parameter int               WIDTH     = 4,
   parameter bit               MSB_FIRST = 1'b0,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0,
   parameter int               UFC_W     = 8
) (
   input  logic             clk_b,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             frame,
   output logic             underflow,
   output logic [UFC_W-1:0] uf_count,
   input  logic             clr_uf
);

   localparam int               CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [UFC_W-1:0] UFC_MAX  = '1;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             load;
   logic             accept;
   logic [WIDTH-1:0] shifted;

   // A word boundary happens on the last bit slot; while disabled the counter
   // parks there, so the first enabled edge is always a load.
   assign load      = en & (cnt == CNT_LAST);
   // The holding buffer frees up on a load edge, so a new word can be taken
   // in the very cycle the old one moves into the shift register.
   assign din_ready = ~hold_full | load;
   assign accept    = din_valid & din_ready;
   assign frame     = en & (cnt == '0);
   assign dout      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

   // Shift toward the output position, zero fill behind.
   assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

   // bit slot counter
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n)          cnt <= CNT_LAST;
      else if (!en)        cnt <= CNT_LAST;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
   end

   // shift register: load from hold (or idle) at the boundary, else shift
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n)       shreg <= IDLE_WORD;
      else if (load)    shreg <= hold_full ? hold : IDLE_WORD;
      else if (en)      shreg <= shifted;
   end

   // holding buffer; a same-cycle accept refills it after the load drains it
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold      <= din;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

   // underflow accounting; clear has priority over a same-edge underflow
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         underflow <= 1'b0;
         uf_count  <= '0;
      end else if (clr_uf) begin
         underflow <= 1'b0;
         uf_count  <= '0;
      end else if (load && !hold_full) begin
         underflow <= 1'b1;
         if (uf_count != UFC_MAX) uf_count <= uf_count + UFC_W'(1);
      end
   end

endmodule

// File: tb/tb_tx_nt1_serializer.sv
// ---------------------------------------------------------------------------
// tb_tx_nt1_serializer
// Two serializers (LSB-first and MSB-first) share one stimulus stream. A
// word-level model (current word + bit index, one-entry hold, slot phase)
// predicts every output each cycle; literal expectations pin key sequences.
// ---------------------------------------------------------------------------
module tb_tx_nt1_serializer;

   localparam int           W     = 4;
   localparam int           UFC_W = 8;
   localparam logic [W-1:0] IDLE  = 4'h5;
   localparam int           UFMAX = (1 << UFC_W) - 1;

   logic             clk_b = 1'b0;
   logic             rst_n;
   logic             en;
   logic [W-1:0]     din;
   logic             din_valid;
   logic             clr_uf;
   logic             din_ready, dout, frame, underflow;
   logic [UFC_W-1:0] uf_count;
   logic             din_ready_m, dout_m, frame_m, underflow_m;
   logic [UFC_W-1:0] uf_count_m;

   tx_nt1_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_WORD(IDLE), .UFC_W(UFC_W)) dut (
      .clk_b(clk_b), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .dout(dout), .frame(frame), .underflow(underflow),
      .uf_count(uf_count), .clr_uf(clr_uf));

   tx_nt1_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_WORD(IDLE), .UFC_W(UFC_W)) dut_m (
      .clk_b(clk_b), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
      .din_ready(din_ready_m), .dout(dout_m), .frame(frame_m), .underflow(underflow_m),
      .uf_count(uf_count_m), .clr_uf(clr_uf));

   always #5 clk_b = ~clk_b;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int           m_phase = W - 1;   // bit slot about to be closed by the next edge
   int           m_bidx  = 0;       // bits of m_cur already sent
   int           m_ufc   = 0;
   logic [W-1:0] m_cur   = IDLE;
   logic [W-1:0] m_hword = '0;
   logic         m_hfull = 1'b0;
   logic         m_uf    = 1'b0;
   logic         m_acc   = 1'b0;
   logic         m_load, m_ready, m_frame, exp_l, exp_m;

   assign m_load  = en && (m_phase == W - 1);
   assign m_ready = !m_hfull || m_load;
   assign m_frame = en && (m_phase == 0);
   assign exp_l   = (m_bidx < W) ? m_cur[m_bidx] : 1'b0;
   assign exp_m   = (m_bidx < W) ? m_cur[W-1-m_bidx] : 1'b0;

   always @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= W - 1;
         m_bidx  <= 0;
         m_ufc   <= 0;
         m_cur   <= IDLE;
         m_hfull <= 1'b0;
         m_uf    <= 1'b0;
         m_acc   <= 1'b0;
      end else begin
         m_acc <= din_valid && m_ready;
         if (m_load) begin
            m_cur  <= m_hfull ? m_hword : IDLE;
            m_bidx <= 0;
         end else if (en) begin
            m_bidx <= m_bidx + 1;
         end
         if (clr_uf) begin
            m_uf  <= 1'b0;
            m_ufc <= 0;
         end else if (m_load && !m_hfull) begin
            m_uf  <= 1'b1;
            m_ufc <= (m_ufc < UFMAX) ? m_ufc + 1 : UFMAX;
         end
         if (din_valid && m_ready) begin
            m_hword <= din;
            m_hfull <= 1'b1;
         end else if (m_load) begin
            m_hfull <= 1'b0;
         end
         m_phase <= en ? (m_phase + 1) % W : W - 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic run = 1'b0;
   always @(negedge clk_b) begin
      if (run) begin
         chk("dout",        32'(dout),        32'(exp_l));
         chk("dout_msb",    32'(dout_m),      32'(exp_m));
         chk("frame",       32'(frame),       32'(m_frame));
         chk("frame_msb",   32'(frame_m),     32'(m_frame));
         chk("din_ready",   32'(din_ready),   32'(m_ready));
         chk("din_ready_m", 32'(din_ready_m), 32'(m_ready));
         chk("underflow",   32'(underflow),   32'(m_uf));
         chk("uf_count",    32'(uf_count),    32'(m_ufc));
         chk("uf_count_m",  32'(uf_count_m),  32'(m_ufc));
         chk("underflow_m", 32'(underflow_m), 32'(m_uf));
      end
   end

   // ---------------- source driver ----------------
   // mode 0: idle, 1: send txq in order, 2: random words / enable / clear
   int           drv_mode = 0;
   logic [W-1:0] txq[$];

   initial begin
      forever begin
         @(posedge clk_b);
         #2;
         case (drv_mode)
            1: begin
               if (m_acc && txq.size() > 0) void'(txq.pop_front());
               din_valid = (txq.size() > 0);
               din       = (txq.size() > 0) ? txq[0] : '0;
            end
            2: begin
               if (!(din_valid && !m_acc)) begin
                  din_valid = ($urandom_range(0, 3) != 0);
                  din       = W'($urandom);
               end
               if ($urandom_range(0, 15) == 0) en = ~en;
               clr_uf = ($urandom_range(0, 31) == 0);
            end
            default: din_valid = 1'b0;
         endcase
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_b);
      #3;
   endtask

   logic [11:0] cap_l, cap_m;
   logic [3:0]  c4_l, c4_m;
   bit          found;

   initial begin
      rst_n = 1'b0; en = 1'b0; din = '0; din_valid = 1'b0; clr_uf = 1'b0;
      repeat (3) @(posedge clk_b);
      run = 1'b1;
      @(negedge clk_b);
      chk("rst_dout",  32'(dout),      32'(1));
      chk("rst_doutm", 32'(dout_m),    32'(0));
      chk("rst_frame", 32'(frame),     32'(0));
      chk("rst_ready", 32'(din_ready), 32'(1));
      chk("rst_ufc",   32'(uf_count),  32'(0));

      // back-to-back words A, 3, C
      wait_cyc(1);
      txq = '{4'hA, 4'h3, 4'hC};
      drv_mode = 1;
      wait_cyc(1);
      rst_n = 1'b1;
      en    = 1'b1;
      repeat (2) @(posedge clk_b);          // E1 (idle load, A taken), E2
      @(negedge clk_b);
      chk("stall_ready", 32'(din_ready), 32'(0));
      repeat (2) @(posedge clk_b);          // E3, E4
      @(negedge clk_b);
      chk("load_ready", 32'(din_ready), 32'(1));
      @(posedge clk_b);                     // E5: A loaded
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_b);
         cap_l = {cap_l[10:0], dout};
         cap_m = {cap_m[10:0], dout_m};
      end
      chk("stream_lsb", 32'(cap_l), 32'(12'b0101_1100_0011));
      chk("stream_msb", 32'(cap_m), 32'(12'b1010_0011_1100));
      chk("ufc_first",  32'(uf_count), 32'(1));

      // clear on an underflow-load edge: the clear wins
      clr_uf = 1'b1;
      @(posedge clk_b);
      #3 clr_uf = 1'b0;
      @(negedge clk_b);
      chk("clr_uf_flag", 32'(underflow), 32'(0));
      chk("clr_uf_cnt",  32'(uf_count),  32'(0));
      c4_l = {3'b0, dout};
      for (int i = 1; i < 4; i++) begin
         @(negedge clk_b);
         c4_l = {c4_l[2:0], dout};
      end
      chk("idle_bits", 32'(c4_l), 32'(4'b1010));
      @(negedge clk_b);
      chk("uf_one_more", 32'(uf_count),  32'(1));
      chk("uf_sticky",   32'(underflow), 32'(1));

      // a word after the gap goes out intact (model checks bits)
      txq.push_back(4'h6);
      wait_cyc(12);

      // saturation: >300 idle loads
      repeat (1210) @(posedge clk_b);
      @(negedge clk_b);
      chk("uf_sat", 32'(uf_count), 32'(UFMAX));
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk_b);
         if (m_phase == W - 1) found = 1'b1;
      end
      chk("find_load", 32'(found), 32'(1));
      clr_uf = 1'b1;
      @(posedge clk_b);
      #3 clr_uf = 1'b0;
      @(negedge clk_b);
      chk("sat_clr", 32'(uf_count), 32'(0));

      // randomized traffic with enable toggles and clears
      drv_mode = 2;
      repeat (2500) @(posedge clk_b);
      #3;
      drv_mode = 0;
      en = 1'b1;
      clr_uf = 1'b0;

      // async reset mid-stream
      txq = '{4'hE, 4'h9};
      drv_mode = 1;
      wait_cyc(7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dout",  32'(dout),      32'(IDLE[0]));
      chk("mid_rst_doutm", 32'(dout_m),    32'(IDLE[W-1]));
      chk("mid_rst_frame", 32'(frame),     32'(0));
      chk("mid_rst_ready", 32'(din_ready), 32'(1));
      wait_cyc(1);
      drv_mode = 0;
      wait_cyc(1);
      txq = '{4'h8};
      drv_mode = 1;
      wait_cyc(1);
      rst_n = 1'b1;
      repeat (5) @(posedge clk_b);          // E1 idle load, E5 loads 8
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_b);
         c4_l = {c4_l[2:0], dout};
         c4_m = {c4_m[2:0], dout_m};
      end
      chk("post_rst_lsb", 32'(c4_l), 32'(4'b0001));
      chk("post_rst_msb", 32'(c4_m), 32'(4'b1000));

      wait_cyc(4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
